// File: rtl/theta_update_unit.sv
`default_nettype none
// ============================================================================
// theta_update_unit : serial gradient-descent step, theta_j <- sat(theta_j - (alpha*g_j)>>>SHIFT)
// Rev 1.0
// ============================================================================
module theta_update_unit #(
    parameter int N        = 3,
    parameter int THETA_W  = 16,
    parameter int GRAD_W   = 32,
    parameter int ALPHA_W  = 16,
    parameter int SHIFT    = 16,
    parameter int MAX_ITER = 1000,
    parameter int ITER_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [THETA_W*N-1:0]   theta_init,
    input  logic [ALPHA_W-1:0]     alpha,
    input  logic [GRAD_W*N-1:0]    gradient_vector,
    input  logic                   grad_valid,
    output logic                   grad_ready,
    output logic [THETA_W*N-1:0]   theta,
    output logic                   theta_valid,
    output logic [ITER_W-1:0]      iter_count,
    output logic                   busy,
    output logic                   done
);
    localparam int PROD_W = GRAD_W + ALPHA_W + 1;
    localparam int DIFF_W = PROD_W + 1;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [DIFF_W-1:0] SAT_HI = {{(DIFF_W-THETA_W+1){1'b0}}, {(THETA_W-1){1'b1}}};
    localparam logic signed [DIFF_W-1:0] SAT_LO = {{(DIFF_W-THETA_W+1){1'b1}}, {(THETA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_GRAD = 3'd1,
        S_UPDATE    = 3'd2,
        S_COMMIT    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic signed [THETA_W-1:0]  work_q  [N];
    logic signed [THETA_W-1:0]  work_d  [N];
    logic signed [THETA_W-1:0]  theta_q [N];
    logic signed [THETA_W-1:0]  theta_d [N];
    logic signed [GRAD_W-1:0]   grad_q  [N];
    logic signed [GRAD_W-1:0]   grad_d  [N];
    logic [ALPHA_W-1:0]         alpha_q, alpha_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ITER_W-1:0]          iter_q, iter_d;
    logic                       done_q, done_d;
    logic                       valid_q, valid_d;

    logic signed [THETA_W-1:0]  init_elem [N];
    logic signed [GRAD_W-1:0]   grad_elem [N];

    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_pack
            assign init_elem[j] = theta_init[THETA_W*N-1-THETA_W*j -: THETA_W];
            assign grad_elem[j] = gradient_vector[GRAD_W*N-1-GRAD_W*j -: GRAD_W];
            assign theta[THETA_W*N-1-THETA_W*j -: THETA_W] = theta_q[j];
        end
    endgenerate

    // Per-element datapath; everything is kept at full width until the final clamp.
    logic signed [THETA_W-1:0]  cur_theta;
    logic signed [GRAD_W-1:0]   cur_grad;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   step;
    logic signed [DIFF_W-1:0]   diff;
    logic signed [THETA_W-1:0]  new_theta;

    assign cur_theta = work_q[idx_q];
    assign cur_grad  = grad_q[idx_q];
    assign prod      = $signed({{(ALPHA_W+1){cur_grad[GRAD_W-1]}}, cur_grad})
                     * $signed({{GRAD_W{1'b0}}, 1'b0, alpha_q});
    assign step      = prod >>> SHIFT;
    assign diff      = {{(DIFF_W-THETA_W){cur_theta[THETA_W-1]}}, cur_theta}
                     - {step[PROD_W-1], step};
    assign new_theta = (diff > SAT_HI) ? SAT_HI[THETA_W-1:0] :
                       (diff < SAT_LO) ? SAT_LO[THETA_W-1:0] : diff[THETA_W-1:0];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        theta_d = theta_q;
        grad_d  = grad_q;
        alpha_d = alpha_q;
        idx_d   = idx_q;
        iter_d  = iter_q;
        done_d  = done_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    work_d  = init_elem;
                    theta_d = init_elem;
                    alpha_d = alpha;
                    iter_d  = '0;
                    done_d  = 1'b0;
                    state_d = S_WAIT_GRAD;
                end
            end
            S_WAIT_GRAD: begin
                if (grad_valid) begin
                    grad_d  = grad_elem;
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                work_d[idx_q] = new_theta;
                // The commit register is loaded on the edge into COMMIT so the
                // new theta and its valid pulse are visible during COMMIT itself.
                if (idx_q == IDX_W'(N-1)) begin
                    theta_d = work_d;
                    valid_d = 1'b1;
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                if (iter_q == ITER_W'(MAX_ITER)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_GRAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N; k++) begin
                work_q[k]  <= '0;
                theta_q[k] <= '0;
                grad_q[k]  <= '0;
            end
            alpha_q <= '0;
            idx_q   <= '0;
            iter_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            theta_q <= theta_d;
            grad_q  <= grad_d;
            alpha_q <= alpha_d;
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign grad_ready  = (state_q == S_WAIT_GRAD);
    assign busy        = (state_q == S_WAIT_GRAD) || (state_q == S_UPDATE) || (state_q == S_COMMIT);
    assign theta_valid = valid_q;
    assign iter_count  = iter_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_theta_update_unit.sv
`default_nettype none
// ============================================================================
// tb_theta_update_unit : scoreboard bench, randomized gradients vs arithmetic reference model
// Rev 1.0
// ============================================================================
module tb_theta_update_unit;
    localparam int N    = 3;
    localparam int TW   = 16;
    localparam int GW   = 32;
    localparam int AW   = 16;
    localparam int SH   = 8;
    localparam int MAXI = 3;
    localparam int IW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TW*N-1:0]   theta_init;
    logic [AW-1:0]     alpha;
    logic [GW*N-1:0]   gradient_vector;
    logic              grad_valid;
    logic              grad_ready;
    logic [TW*N-1:0]   theta;
    logic              theta_valid;
    logic [IW-1:0]     iter_count;
    logic              busy;
    logic              done;

    theta_update_unit #(
        .N(N), .THETA_W(TW), .GRAD_W(GW), .ALPHA_W(AW),
        .SHIFT(SH), .MAX_ITER(MAXI), .ITER_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .theta_init(theta_init), .alpha(alpha),
        .gradient_vector(gradient_vector), .grad_valid(grad_valid), .grad_ready(grad_ready),
        .theta(theta), .theta_valid(theta_valid), .iter_count(iter_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic signed [TW-1:0] m_theta [N];
    logic [AW-1:0]        m_alpha;
    int                   m_iter;
    int                   last_hs = -1;

    typedef struct {
        logic [TW*N-1:0] theta;
        int              iter;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW*N-1:0] pk3(input int a, input int b, input int c);
        return {a[TW-1:0], b[TW-1:0], c[TW-1:0]};
    endfunction

    function automatic logic [GW*N-1:0] gk3(input int a, input int b, input int c);
        return {a[GW-1:0], b[GW-1:0], c[GW-1:0]};
    endfunction

    function automatic logic [TW*N-1:0] pack_m();
        logic [TW*N-1:0] v;
        for (int j = 0; j < N; j++) v[TW*N-1-TW*j -: TW] = m_theta[j];
        return v;
    endfunction

    // Reference: exact product, floor division by 2^SHIFT, subtract, clamp.
    function automatic logic signed [TW-1:0] ref_elem(input logic signed [TW-1:0] th,
                                                      input logic signed [GW-1:0] g,
                                                      input logic [AW-1:0] a);
        longint prod, step, diff, scale;
        scale = longint'(1) << SH;
        prod  = longint'(g) * longint'(a);
        if (prod >= 0) step = prod / scale;
        else           step = -((-prod + scale - 1) / scale);
        diff = longint'(th) - step;
        if (diff > 32767)       diff = 32767;
        else if (diff < -32768) diff = -32768;
        return diff[TW-1:0];
    endfunction

    function automatic logic [GW-1:0] rnd_g();
        int v;
        case ($urandom_range(0, 2))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 1 << 17)) - (1 << 16);
            default: v = int'($urandom_range(0, 2000)) - 1000;
        endcase
        return v;
    endfunction

    function automatic logic [GW*N-1:0] rnd_vec();
        return {rnd_g(), rnd_g(), rnd_g()};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " theta"}, theta, 0);
        chk({tag, " theta_valid"}, theta_valid, 0);
        chk({tag, " iter_count"}, iter_count, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " grad_ready"}, grad_ready, 0);
    endtask

    // Called at a negedge with the DUT idle or done.
    task automatic do_start(input logic [TW*N-1:0] init, input logic [AW-1:0] a);
        theta_init = init;
        alpha      = a;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        theta_init = {$urandom, $urandom};
        alpha      = AW'($urandom);
        for (int j = 0; j < N; j++) m_theta[j] = init[TW*N-1-TW*j -: TW];
        m_alpha = a;
        m_iter  = 0;
        last_hs = -1;
        chk("start theta", theta, init);
        chk("start iter_count", iter_count, 0);
        chk("start done", done, 0);
        chk("start busy", busy, 1);
        chk("start grad_ready", grad_ready, 1);
    endtask

    task automatic send_grad(input logic [GW*N-1:0] g, input bit b2b, input bit poke_start);
        int   waitc = 0;
        exp_t e;
        gradient_vector = g;
        grad_valid      = 1'b1;
        while (!grad_ready) begin
            start = poke_start && (waitc == 0);
            if (start) begin
                theta_init = {$urandom, $urandom};
                alpha      = AW'($urandom);
            end
            @(negedge clk);
            waitc++;
            if (waitc > 40) begin
                start      = 1'b0;
                grad_valid = 1'b0;
                checks++;
                errors++;
                $display("FAIL handshake timeout: grad_ready low for %0d cycles, expected high", waitc);
                return;
            end
        end
        start = 1'b0;
        if (b2b && last_hs >= 0) chk("back-to-back handshake cycle", cyc, last_hs + N + 2);
        last_hs = cyc;
        for (int j = 0; j < N; j++)
            m_theta[j] = ref_elem(m_theta[j], g[GW*N-1-GW*j -: GW], m_alpha);
        m_iter++;
        e.theta = pack_m();
        e.iter  = m_iter;
        e.cyc   = cyc + N + 1;
        sb.push_back(e);
        @(negedge clk);
        grad_valid      = 1'b0;
        gradient_vector = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done();
        int w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("done raised", done, 1);
        chk("busy after done", busy, 0);
        chk("grad_ready after done", grad_ready, 0);
        chk("iter_count at done", iter_count, MAXI);
        chk("theta at done", theta, pack_m());
        chk("scoreboard drained at done", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (theta_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected theta_valid: got 1 with nothing pending, expected 0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("commit theta", theta, e.theta);
                chk("commit iter_count", iter_count, e.iter);
                chk("commit latency cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; grad_valid = 1'b0;
        theta_init = '0; alpha = '0; gradient_vector = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Basic update with exact latency and single-cycle valid pulse
        do_start(pk3(100, -50, 0), 16);
        send_grad(gk3(320, -160, 17), 0, 0);
        repeat (N) @(negedge clk);
        chk("basic theta", theta, pk3(80, -40, -1));
        chk("basic theta_valid", theta_valid, 1);
        chk("basic iter_count", iter_count, 1);
        @(negedge clk);
        chk("basic valid pulse width", theta_valid, 0);
        chk("basic grad_ready after commit", grad_ready, 1);
        send_grad(rnd_vec(), 1, 0);
        send_grad(rnd_vec(), 1, 1);
        wait_done();

        // Gradients offered after termination must be refused
        gradient_vector = rnd_vec();
        grad_valid      = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("grad_ready while done", grad_ready, 0);
        end
        grad_valid = 1'b0;
        chk("theta held while done", theta, pack_m());
        chk("iter held while done", iter_count, MAXI);

        // Floor rounding toward minus infinity
        do_start(pk3(0, 0, 0), 16);
        send_grad(gk3(-17, 17, 0), 0, 0);
        repeat (N) @(negedge clk);
        chk("floor theta", theta, pk3(2, -1, 0));
        @(negedge clk);
        send_grad(rnd_vec(), 1, 1);
        send_grad(rnd_vec(), 1, 1);
        wait_done();

        // Saturation at both rails
        do_start(pk3(32767, -32768, 5), 256);
        send_grad(gk3(-65536, 65536, 0), 0, 0);
        repeat (N) @(negedge clk);
        chk("saturation theta", theta, pk3(32767, -32768, 5));
        @(negedge clk);
        send_grad(rnd_vec(), 1, 0);
        send_grad(rnd_vec(), 1, 0);
        wait_done();

        // Asynchronous reset between edges while idx=1 is being processed
        do_start({$urandom, $urandom}, AW'($urandom_range(1, 600)));
        send_grad(rnd_vec(), 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("after async reset");
        do_start(pk3(-1234, 4321, 77), 100);
        send_grad(rnd_vec(), 0, 0);
        send_grad(rnd_vec(), 1, 1);
        send_grad(rnd_vec(), 1, 1);
        wait_done();

        // Randomized runs with mixed gaps, back-to-back traffic and ignored starts
        repeat (8) begin
            do_start({$urandom, $urandom},
                     ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'($urandom_range(0, 512)));
            for (int i = 0; i < MAXI; i++) begin
                bit b2b;
                b2b = ($urandom_range(0, 1) == 1);
                if (!b2b) repeat ($urandom_range(0, 6)) @(negedge clk);
                send_grad(rnd_vec(), b2b, ($urandom_range(0, 1) == 1));
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("scoreboard empty at end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/theta_update_unit.md
Name: theta_update_unit

Overview:
Gradient-descent parameter update stage. It sits directly downstream of the X^T·(Xθ−Y) gradient block. It accepts one packed gradient vector per iteration and computes θ_j ← sat(θ_j − (α·g_j)>>>SHIFT) serially, one element per cycle. It holds θ between iterations, presents it to the upstream Xθ stage, and counts iterations up to MAX_ITER.

Parameters:
N, 3, number of features (θ elements)
THETA_W, 16, signed θ element width
GRAD_W, 32, signed gradient element width
ALPHA_W, 16, unsigned learning-rate width
SHIFT, 16, arithmetic right shift applied to α·g (fixed-point scale of α)
MAX_ITER, 1000, iterations before done
ITER_W, 16, iteration counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; loads theta_init/alpha and begins a run
theta_init  input  THETA_W*N  initial θ, packed
alpha  input  ALPHA_W  learning rate, unsigned
gradient_vector  input  GRAD_W*N  packed gradient from upstream stage
grad_valid  input  1  gradient_vector valid
grad_ready  output  1  block accepts gradient this cycle
theta  output  THETA_W*N  current committed θ, packed
theta_valid  output  1  one-cycle pulse when theta is updated
iter_count  output  ITER_W  completed iterations in current run
busy  output  1  run in progress
done  output  1  MAX_ITER iterations completed; held until the next start

Behaviour:
- Packing, MSB-first: element j of gradient_vector is [GRAD_W*N-1-GRAD_W*j -: GRAD_W]. θ uses the same scheme with THETA_W.
- Reset (async): all outputs 0, state IDLE, working regs 0.
- States:
  - IDLE: start → latch theta_init into working θ and theta output; latch alpha; iter_count=0; done=0 → WAIT_GRAD.
  - WAIT_GRAD: grad_ready=1. grad_valid&grad_ready → latch full gradient_vector, idx=0 → UPDATE.
  - UPDATE: one element per cycle, idx 0..N-1, writing working θ only; after idx=N-1 → COMMIT.
  - COMMIT: theta ← working θ, all elements at once. theta_valid=1 for exactly this cycle. iter_count+1. If the new count == MAX_ITER → DONE, else → WAIT_GRAD.
  - DONE: done=1, busy=0, grad_ready=0. start → same actions as start in IDLE.
- busy=1 in WAIT_GRAD, UPDATE and COMMIT. grad_ready=0 outside WAIT_GRAD; grad_valid is ignored there and no data is lost upstream (valid/ready rule).
- Latency: the handshake cycle is T. theta_valid and the new theta appear at T+N+1. Back-to-back: next grad_ready at T+N+2.
- Arithmetic, per element:
  - prod = signed(g_j) × signed({1'b0,alpha}), GRAD_W+ALPHA_W+1 bits.
  - step = prod >>> SHIFT (arithmetic shift, floor toward −∞).
  - diff = θ_j − step, computed at full width.
  - θ_j = diff saturated to [−2^(THETA_W−1), 2^(THETA_W−1)−1]. No wrap-around permitted.
- start is ignored in WAIT_GRAD/UPDATE/COMMIT.
- alpha and theta_init are sampled only on an accepted start.
- gradient_vector is sampled only on the handshake; later changes do not affect the update in progress.
- Reset mid-UPDATE: immediate return to IDLE; theta, theta_valid, iter_count, done all 0.
- MAX_ITER=1: done after the first COMMIT.

Test Plan:
1. Basic update (SHIFT=8): theta_init={100,−50,0}, alpha=16, start; gradient={320,−160,17} handshake at T → at T+4 theta={80,−40,−1}, theta_valid pulse 1 cycle, iter_count=1, grad_ready=1 next cycle.
2. Floor rounding (SHIFT=8): theta_init={0,0,0}, alpha=16, gradient={−17,17,0} → theta={2,−1,0}.
3. Saturation (SHIFT=8, alpha=256): theta_init={32767,−32768,5}, gradient={−65536,65536,0} → theta={32767,−32768,5}.
4. Termination (MAX_ITER=2): two accepted gradients → done=1, busy=0, iter_count=2 after the second COMMIT. A third grad_valid sees grad_ready=0 and theta is unchanged. A new start clears done and iter_count=0.
5. Backpressure: hold grad_valid=1 with a new gradient during UPDATE → not accepted; accepted in the first WAIT_GRAD cycle; exactly one update per handshake; start pulses while busy are ignored.
6. Async reset asserted mid-UPDATE (idx=1) between clock edges → outputs 0 immediately, IDLE; a subsequent start runs normally from the new theta_init.
